// File: rtl/tt_um_nibble_sum_uart_tx.sv
// Nibble-sum UART transmitter: on a start strobe, capture ui_in, add its two nibbles
// and send the zero-extended sum (or the raw byte in raw mode) as one 8N1 frame.
module tt_um_nibble_sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] strobe_sync_q;
  logic [SYNC_STAGES-1:0] mode_sync_q;
  logic                   strobe_prev_q;
  logic                   strobe_s;
  logic                   mode_s;
  logic                   start_edge;

  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [4:0]      sum_q, sum_d;
  logic            done_q, done_d;

  logic [4:0] nib_sum;
  logic       bit_end;
  logic       tx;
  logic       busy;
  logic       unused;

  assign strobe_s   = strobe_sync_q[SYNC_STAGES-1];
  assign mode_s     = mode_sync_q[SYNC_STAGES-1];
  assign start_edge = strobe_s & ~strobe_prev_q;

  // Carry is kept: 15 + 15 = 30 needs all five bits.
  assign nib_sum = {1'b0, ui_in[3:0]} + {1'b0, ui_in[7:4]};
  assign bit_end = (baud_q == CntLast);

  // Synchronise the asynchronous strobe and mode pins, and remember the previous strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync_q <= '0;
      mode_sync_q   <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], uio_in[0]};
      mode_sync_q   <= {mode_sync_q[SYNC_STAGES-2:0], uio_in[1]};
      strobe_prev_q <= strobe_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: edges outside IDLE are dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_edge) state_d = StStart;
      StStart: if (bit_end) state_d = StData;
      StData:  if (bit_end && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:  if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: line idles high, start bit low, data from the shifter LSB.
  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state_q)
      StIdle:  busy = 1'b0;
      StStart: tx = 1'b0;
      StData:  tx = shift_q[0];
      StStop:  tx = 1'b1;
      default: begin
        tx   = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  // Datapath next state: capture, baud counting, shifting and the done pulse.
  always_comb begin
    baud_d    = '0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    sum_d     = sum_q;
    // Registered so done lands on the first IDLE cycle, together with busy=0.
    done_d    = (state_q == StStop) && bit_end;
    if (state_q == StIdle) begin
      bit_idx_d = '0;
      if (start_edge) begin
        shift_d = mode_s ? ui_in : {3'b000, nib_sum};
        sum_d   = nib_sum;
      end
    end else begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if ((state_q == StData) && bit_end) begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      sum_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
    end
  end

  assign uo_out  = {sum_q, done_q, busy, tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign unused = &{1'b0, ena, uio_in[7:2]};

endmodule
